// File: rtl/sincos_arbiter_if.sv
// rtl/sincos_arbiter_if.sv - requester, result and CORDIC core signal bundle for sincos_arbiter
interface sincos_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_angle;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_valid;
    logic [32*N_REQ-1:0] resp_data;
    logic                cordic_phase_tvalid;
    logic [15:0]         cordic_phase_tdata;
    logic                cordic_dout_tvalid;
    logic [31:0]         cordic_dout_tdata;
    logic                tag_error;

    modport slave (
        input  req_valid, req_angle, cordic_dout_tvalid, cordic_dout_tdata,
        output req_ready, resp_valid, resp_data, cordic_phase_tvalid, cordic_phase_tdata, tag_error
    );

    modport master (
        output req_valid, req_angle, cordic_dout_tvalid, cordic_dout_tdata,
        input  req_ready, resp_valid, resp_data, cordic_phase_tvalid, cordic_phase_tdata, tag_error
    );
endinterface

// File: rtl/sincos_arbiter.sv
// rtl/sincos_arbiter.sv - round-robin sharing of one CORDIC sin/cos core; SINCOS_ARB_WRAP_EN adds a phase wrap stage
module sincos_arbiter #(
    parameter int N_REQ          = 4,
    parameter int CORDIC_LATENCY = 20
) (
    input logic            clk,
    input logic            rst,
    sincos_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(CORDIC_LATENCY + 1);
    localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);

    logic [PW-1:0] ptr;
    logic [PW:0]   cand;
    logic [PW:0]   ptr_inc;
    logic          grant_any;
    logic [PW-1:0] grant_idx;
    logic [2:0]    grant_id;
    logic [N_REQ-1:0] grant;
    logic [15:0]   grant_angle;

    logic          s_valid;
    logic [15:0]   s_angle;
    logic [2:0]    s_id;

    logic          issue_valid;
    logic [15:0]   issue_angle;
    logic [2:0]    issue_id;

    logic [3:0]    tag_line [CORDIC_LATENCY];
    logic          tag_valid;
    logic [2:0]    tag_id;
    logic [CW-1:0] mask_cnt;

    logic [N_REQ-1:0]    resp_valid_q;
    logic [32*N_REQ-1:0] resp_data_q;
    logic                tag_error_q;

    // Round-robin search: first valid requester at or after ptr, with wrap; nothing granted in reset
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && cand[PW-1:0] == PW'(i) && bus.req_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = PW'(i);
                end
            end
        end
        if (rst) grant_any = 1'b0;
    end

    // Decode the winner into the one-hot ready vector and select its angle
    always_comb begin
        grant       = '0;
        grant_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_any && grant_idx == PW'(i)) begin
                grant[i]    = 1'b1;
                grant_angle = bus.req_angle[16*i +: 16];
            end
        end
    end

    assign grant_id = 3'(grant_idx);
    assign bus.req_ready = grant;

    // Next pointer is one past the winner, wrapping at N_REQ
    always_comb begin
        ptr_inc = {1'b0, grant_idx} + 1'b1;
        if (ptr_inc >= NREQ_W) ptr_inc = '0;
    end

    // Pointer moves only on an actual transfer
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (grant_any) ptr <= ptr_inc[PW-1:0];
    end

`ifdef SINCOS_ARB_WRAP_EN
    logic          w_valid;
    logic [15:0]   w_angle;
    logic [2:0]    w_id;

    // Fold one turn of 2*pi (0xC90E in Q3.13) back into [-pi, pi]
    function automatic logic [15:0] wrap_phase(input logic [15:0] a);
        if ($signed(a) > $signed(16'h6487)) return a - 16'hC90E;
        else if ($signed(a) < $signed(16'h9B79)) return a + 16'hC90E;
        else return a;
    endfunction

    // Extra register stage carrying the wrapped angle with its id and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= 1'b0;
            w_angle <= '0;
            w_id    <= '0;
        end else begin
            w_valid <= grant_any;
            w_angle <= wrap_phase(grant_angle);
            w_id    <= grant_id;
        end
    end

    assign s_valid = w_valid;
    assign s_angle = w_angle;
    assign s_id    = w_id;
`else
    assign s_valid = grant_any;
    assign s_angle = grant_angle;
    assign s_id    = grant_id;
`endif

    // Issue register toward the core; data holds when nothing is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_angle <= '0;
            issue_id    <= '0;
        end else begin
            issue_valid <= s_valid;
            if (s_valid) begin
                issue_angle <= s_angle;
                issue_id    <= s_id;
            end
        end
    end

    assign bus.cordic_phase_tvalid = issue_valid;
    assign bus.cordic_phase_tdata  = issue_angle;

    // Tag delay line matched to the core latency so each result finds its owner
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CORDIC_LATENCY; i++) tag_line[i] <= '0;
        end else begin
            tag_line[0] <= {issue_valid, issue_id};
            for (int i = 1; i < CORDIC_LATENCY; i++) tag_line[i] <= tag_line[i-1];
        end
    end

    assign tag_valid = tag_line[CORDIC_LATENCY-1][3];
    assign tag_id    = tag_line[CORDIC_LATENCY-1][2:0];

    // Registered result capture, one strobe per delivered result
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (tag_valid && tag_id == 3'(i)) begin
                    resp_valid_q[i]         <= 1'b1;
                    resp_data_q[32*i +: 32] <= bus.cordic_dout_tdata;
                end
            end
        end
    end

    // Core outputs of phases discarded by reset still emerge for a full latency, so the check waits them out
    always_ff @(posedge clk) begin
        if (rst) mask_cnt <= CW'(CORDIC_LATENCY);
        else if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
    end

    // Sticky flag when core tvalid and tag line disagree
    always_ff @(posedge clk) begin
        if (rst) tag_error_q <= 1'b0;
        else if (mask_cnt == '0 && bus.cordic_dout_tvalid != tag_valid) tag_error_q <= 1'b1;
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.tag_error  = tag_error_q;
endmodule

// File: tb/tb_sincos_arbiter.sv
// tb/tb_sincos_arbiter.sv - scoreboard bench for sincos_arbiter with a fixed-latency core model
`timescale 1ns/1ps
module tb_sincos_arbiter;
    localparam int N_REQ = 4;
    localparam int LAT   = 20;
`ifdef SINCOS_ARB_WRAP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic spur;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sincos_arbiter_if #(.N_REQ(N_REQ)) bus ();
    sincos_arbiter #(.N_REQ(N_REQ), .CORDIC_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] core_fn(input logic [15:0] a);
        if (a == 16'h0000) return 32'h0000_4000;
        return {a, ~a};
    endfunction

    function automatic logic [15:0] wrap_exp(input logic [15:0] a);
`ifdef SINCOS_ARB_WRAP_EN
        if (a == 16'h7000) return 16'hA6F2;
        if (a == 16'h9000) return 16'h590E;
`endif
        return a;
    endfunction

    // Core model: fixed latency, never reset, optional spurious tvalid
    logic [LAT-1:0]    pv = '0;
    logic [LAT*32-1:0] pd = '0;
    always @(posedge clk) begin
        pv <= {pv[LAT-2:0], bus.cordic_phase_tvalid};
        pd <= {pd[(LAT-1)*32-1:0], core_fn(bus.cordic_phase_tdata)};
    end
    assign bus.cordic_dout_tvalid = pv[LAT-1] | spur;
    assign bus.cordic_dout_tdata  = pd[LAT*32-1 -: 32];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest expectation in id, data and cycle
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected cyc=%0d got_valid=%b", cyc, bus.resp_valid);
            end else begin
                e = sb.pop_front();
                if (bus.resp_valid !== 4'(1 << e.id) || bus.resp_data[32*e.id +: 32] !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL resp cyc=%0d got_valid=%b got_data=%h exp_id=%0d exp_data=%h exp_cyc=%0d",
                             cyc, bus.resp_valid, bus.resp_data[32*e.id +: 32], e.id, e.data, e.due);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] v, input int g,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3);
        logic [15:0] av [4];
        exp_t e;
        av[0] = a0; av[1] = a1; av[2] = a2; av[3] = a3;
        bus.req_valid = v;
        bus.req_angle = {a3, a2, a1, a0};
        @(negedge clk);
        chk("grant", bus.req_ready, (g < 0) ? 4'b0000 : 4'(1 << g));
        if (g >= 0) begin
            e.id   = g;
            e.data = core_fn(wrap_exp(av[g]));
            e.due  = cyc + LAT + 2 + EXTRA;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(4'b0000, -1, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("drain", 32'(sb.size()), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        spur = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_angle = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_tvalid", bus.cordic_phase_tvalid, 0);
        chk("rst_tdata", bus.cordic_phase_tdata, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_tag_error", bus.tag_error, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = '0;

        // All four continuously valid from ptr=0
        for (int c = 0; c < 8; c++)
            drive(4'hF, c % 4, 16'h1000 + 16'(c*16), 16'h1001 + 16'(c*16),
                  16'h1002 + 16'(c*16), 16'h1003 + 16'(c*16));
        idle(LAT + 6);

        // Single requester 0, angle zero
        drive(4'b0001, 0, 16'h0000, 16'h0AAA, 16'h0BBB, 16'h0CCC);
        idle(LAT + 6);
        chk("tag_error_a", bus.tag_error, 0);

        // Requesters 1 and 3, requester 1 drops its pending request
        drive(4'b1010, 1, 16'h0, 16'h0211, 16'h0, 16'h0213);
        drive(4'b1010, 3, 16'h0, 16'h0221, 16'h0, 16'h0213);
        drive(4'b1000, 3, 16'h0, 16'h0221, 16'h0, 16'h0233);
        drive(4'b1000, 3, 16'h0, 16'h0, 16'h0, 16'h0243);
        drive(4'b0000, -1, 16'h0, 16'h0, 16'h0, 16'h0);
        drive(4'b1001, 0, 16'h0250, 16'h0, 16'h0, 16'h0253);
        idle(LAT + 6);

`ifdef SINCOS_ARB_WRAP_EN
        drive(4'b0100, 2, 16'h0, 16'h0, 16'h7000, 16'h0);
        drive(4'b0001, 0, 16'h9000, 16'h0, 16'h0, 16'h0);
        idle(LAT + 6);
`endif

        // Ten phases in flight, then a one-cycle reset
        for (int c = 0; c < 10; c++)
            drive(4'hF, (c + 1) % 4, 16'h0300 + 16'(c*16), 16'h0301 + 16'(c*16),
                  16'h0302 + 16'(c*16), 16'h0303 + 16'(c*16));
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_forces_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b0100, 2, 16'h0, 16'h0, 16'h0777, 16'h0);
        idle(LAT + 6);
        chk("tag_error_after_rst", bus.tag_error, 0);

        // Spurious core tvalid with no tag
        spur = 1'b1;
        @(negedge clk);
        chk("tag_error_pre", bus.tag_error, 0);
        @(posedge clk);
        #1;
        spur = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tag_error_sticky", bus.tag_error, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tag_error_clear", bus.tag_error, 0);
        chk("final_queue", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
